// File: rtl/argmax_row_scheduler.sv
// Schedules per-row reads of the combination result buffer into the argmax unit.
// Tracks reads through a fixed-latency pipeline and reports row_valid/row_idx, done and abort.
module argmax_row_scheduler #(
  parameter int unsigned FEATURE_ROWS   = 6,
  parameter int unsigned ROW_ADDR_WIDTH = 3,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      done_comb,
  input  logic                      stall,
  output logic                      rd_en,
  output logic [ROW_ADDR_WIDTH-1:0] rd_row,
  output logic                      row_valid,
  output logic [ROW_ADDR_WIDTH-1:0] row_idx,
  output logic                      last_row,
  output logic                      busy,
  output logic                      done,
  output logic                      abort
);

  localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ROW = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      pending_q, pending_d;
  logic [ROW_ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic                      rd_en_q, rd_en_d;
  logic [ROW_ADDR_WIDTH-1:0] rd_row_q, rd_row_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      abort_q, abort_d;
  logic                      flush_c;
  logic                      inflight_c;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    issue_cnt_d = issue_cnt_q;
    rd_en_d     = 1'b0;
    rd_row_d    = '0;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    flush_c     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q || start) begin
          if (done_comb) begin
            state_d   = S_ISSUE;
            pending_d = 1'b0;
          end else begin
            pending_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!done_comb) begin
          state_d     = S_IDLE;
          abort_d     = 1'b1;
          flush_c     = 1'b1;
          issue_cnt_d = '0;
        end else if (!stall) begin
          rd_en_d  = 1'b1;
          rd_row_d = issue_cnt_q;
          if (issue_cnt_q == LAST_ROW) begin
            issue_cnt_d = '0;
            state_d     = S_DRAIN;
          end else begin
            issue_cnt_d = issue_cnt_q + ROW_ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!done_comb) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
          flush_c = 1'b1;
        end else if (!inflight_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      issue_cnt_q <= '0;
      rd_en_q     <= 1'b0;
      rd_row_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      issue_cnt_q <= issue_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_row_q    <= rd_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  // Read-return tracking: zero latency is a straight bypass of the read strobe
  if (READ_LATENCY == 0) begin : g_bypass
    assign row_valid  = rd_en_q;
    assign row_idx    = rd_row_q;
    assign inflight_c = 1'b0;
  end else begin : g_pipe
    logic [READ_LATENCY-1:0]                     pv_q, pv_d;
    logic [READ_LATENCY-1:0][ROW_ADDR_WIDTH-1:0] pr_q, pr_d;

    always_comb begin
      pv_d    = '0;
      pr_d    = '0;
      pv_d[0] = rd_en_q;
      pr_d[0] = rd_row_q;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        pv_d[i] = pv_q[i-1];
        pr_d[i] = pr_q[i-1];
      end
      if (flush_c) begin
        pv_d = '0;
      end
    end

    // Reads not yet at the output stage; the output stage itself is delivering now
    always_comb begin
      inflight_c = rd_en_q;
      for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
        inflight_c = inflight_c | pv_q[i];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pv_q <= '0;
        pr_q <= '0;
      end else begin
        pv_q <= pv_d;
        pr_q <= pr_d;
      end
    end

    assign row_valid = pv_q[READ_LATENCY-1];
    assign row_idx   = pr_q[READ_LATENCY-1];
  end

  assign rd_en    = rd_en_q;
  assign rd_row   = rd_row_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign abort    = abort_q;
  assign last_row = row_valid && (row_idx == LAST_ROW);

endmodule

// File: tb/tb_argmax_row_scheduler.sv
// Self-checking bench for argmax_row_scheduler: vector tables, scoreboard of delivered rows,
// hand sequences for early start, abort, async reset, and a latency/row-count sweep.
module tb_argmax_row_scheduler;

  localparam int unsigned ROWS = 6;
  localparam int unsigned AW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done_comb = 1'b0;
  logic stall = 1'b0;

  logic          m_rd_en, m_row_valid, m_last_row, m_busy, m_done, m_abort;
  logic [AW-1:0] m_rd_row, m_row_idx;
  logic          z_rd_en, z_row_valid, z_last_row, z_busy, z_done, z_abort;
  logic [AW-1:0] z_rd_row, z_row_idx;
  logic          t_rd_en, t_row_valid, t_last_row, t_busy, t_done, t_abort;
  logic [AW-1:0] t_rd_row, t_row_idx;
  logic          o_rd_en, o_row_valid, o_last_row, o_busy, o_done, o_abort;
  logic [0:0]    o_rd_row, o_row_idx;

  always #5 clk = ~clk;

  argmax_row_scheduler #(.FEATURE_ROWS(6), .ROW_ADDR_WIDTH(3), .READ_LATENCY(1)) u_main (
    .clk(clk), .rst(rst), .start(start), .done_comb(done_comb), .stall(stall),
    .rd_en(m_rd_en), .rd_row(m_rd_row), .row_valid(m_row_valid), .row_idx(m_row_idx),
    .last_row(m_last_row), .busy(m_busy), .done(m_done), .abort(m_abort));

  argmax_row_scheduler #(.FEATURE_ROWS(6), .ROW_ADDR_WIDTH(3), .READ_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start), .done_comb(done_comb), .stall(stall),
    .rd_en(z_rd_en), .rd_row(z_rd_row), .row_valid(z_row_valid), .row_idx(z_row_idx),
    .last_row(z_last_row), .busy(z_busy), .done(z_done), .abort(z_abort));

  argmax_row_scheduler #(.FEATURE_ROWS(6), .ROW_ADDR_WIDTH(3), .READ_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start), .done_comb(done_comb), .stall(stall),
    .rd_en(t_rd_en), .rd_row(t_rd_row), .row_valid(t_row_valid), .row_idx(t_row_idx),
    .last_row(t_last_row), .busy(t_busy), .done(t_done), .abort(t_abort));

  argmax_row_scheduler #(.FEATURE_ROWS(1), .ROW_ADDR_WIDTH(1), .READ_LATENCY(1)) u_row1 (
    .clk(clk), .rst(rst), .start(start), .done_comb(done_comb), .stall(stall),
    .rd_en(o_rd_en), .rd_row(o_rd_row), .row_valid(o_row_valid), .row_idx(o_row_idx),
    .last_row(o_last_row), .busy(o_busy), .done(o_done), .abort(o_abort));

  typedef struct {
    logic start, dc, stall;
    logic rd_en;
    int   rd_row;
    logic valid;
    int   idx;
    logic last, busy, done, abort;
  } vec_t;

  vec_t tbl[$];
  int   exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    for (int r = 0; r < int'(ROWS); r++) exp_q.push_back(r);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int n;
    n = 0;
    while (m_done !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, int'(m_done), 1);
  endtask

  function automatic vec_t mk(input logic s, dc, st, re, input int rr, input logic v,
                              input int ix, input logic l, b, d, a);
    vec_t x;
    x.start = s; x.dc = dc; x.stall = st; x.rd_en = re; x.rd_row = rr; x.valid = v;
    x.idx = ix; x.last = l; x.busy = b; x.done = d; x.abort = a;
    return x;
  endfunction

  // Scoreboard: every returned row on the main instance must match the next expected row
  always @(posedge clk) begin
    #1;
    if (m_row_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_row: got row_idx %0d with no row expected at %0t",
                 m_row_idx, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("sb_row_idx", int'(m_row_idx), e);
        chk("sb_last_row", int'(m_last_row), (e == int'(ROWS) - 1) ? 1 : 0);
      end
    end
  end

  initial begin
    // nominal run, latency 1
    tbl.push_back(mk(1,1,0, 0,0, 0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,0, 0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,1, 1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,2, 1,1, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,3, 1,2, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4, 1,3, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,5, 1,4, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,0, 1,5, 1,1,0,0));
    tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,1,0));
    tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0));
    // two stall cycles after row 2
    tbl.push_back(mk(1,1,0, 0,0, 0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,0, 0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,1, 1,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,2, 1,1, 0,1,0,0));
    tbl.push_back(mk(0,1,1, 0,0, 1,2, 0,1,0,0));
    tbl.push_back(mk(0,1,1, 0,0, 0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,3, 0,0, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,4, 1,3, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 1,5, 1,4, 0,1,0,0));
    tbl.push_back(mk(0,1,0, 0,0, 1,5, 1,1,0,0));
    tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,1,1,0));
    tbl.push_back(mk(0,1,0, 0,0, 0,0, 0,0,0,0));

    // reset state
    #2;
    chk("rst_rd_en", int'(m_rd_en), 0);
    chk("rst_row_valid", int'(m_row_valid), 0);
    chk("rst_busy", int'(m_busy), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_abort", int'(m_abort), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("idle_busy", int'(m_busy), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start;
      done_comb = tbl[i].dc;
      stall = tbl[i].stall;
      if (tbl[i].start) push_run();
      step();
      chk($sformatf("vec%0d_rd_en", i), int'(m_rd_en), int'(tbl[i].rd_en));
      if (tbl[i].rd_en) chk($sformatf("vec%0d_rd_row", i), int'(m_rd_row), tbl[i].rd_row);
      chk($sformatf("vec%0d_row_valid", i), int'(m_row_valid), int'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d_row_idx", i), int'(m_row_idx), tbl[i].idx);
      chk($sformatf("vec%0d_last_row", i), int'(m_last_row), int'(tbl[i].last));
      chk($sformatf("vec%0d_busy", i), int'(m_busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), int'(m_done), int'(tbl[i].done));
      chk($sformatf("vec%0d_abort", i), int'(m_abort), int'(tbl[i].abort));
    end
    start = 1'b0;

    // early start held pending until done_comb rises; start during busy ignored
    done_comb = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("early_busy0", int'(m_busy), 0);
    repeat (4) begin
      step();
      chk("early_wait_busy", int'(m_busy), 0);
      chk("early_wait_rd_en", int'(m_rd_en), 0);
    end
    done_comb = 1'b1;
    push_run();
    step();
    chk("early_rise_busy", int'(m_busy), 1);
    chk("early_rise_rd_en", int'(m_rd_en), 0);
    step();
    chk("early_first_rd_en", int'(m_rd_en), 1);
    chk("early_first_rd_row", int'(m_rd_row), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("early_done", 30);
    begin
      int busy_n;
      busy_n = 0;
      repeat (10) begin
        step();
        if (m_busy) busy_n++;
      end
      chk("early_no_second_run", busy_n, 0);
    end

    // abort after row 3 issued
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    repeat (4) step();
    chk("abort_pre_rd_row", int'(m_rd_row), 3);
    done_comb = 1'b0;
    step();
    chk("abort_pulse", int'(m_abort), 1);
    chk("abort_busy", int'(m_busy), 0);
    chk("abort_row_valid", int'(m_row_valid), 0);
    exp_q.delete();
    begin
      int ev;
      ev = 0;
      repeat (6) begin
        step();
        if (m_row_valid || m_done || m_abort) ev++;
      end
      chk("abort_quiet", ev, 0);
    end
    done_comb = 1'b1;
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    wait_done("abort_rerun_done", 30);
    repeat (3) step();

    // asynchronous reset during DRAIN
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    repeat (6) step();
    chk("rst_mid_pre_rd_en", int'(m_rd_en), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_rd_en", int'(m_rd_en), 0);
    chk("rst_mid_row_valid", int'(m_row_valid), 0);
    chk("rst_mid_last_row", int'(m_last_row), 0);
    chk("rst_mid_busy", int'(m_busy), 0);
    chk("rst_mid_done", int'(m_done), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      step();
      chk("rst_after_row_valid", int'(m_row_valid), 0);
      chk("rst_after_busy", int'(m_busy), 0);
    end
    start = 1'b1;
    push_run();
    step();
    start = 1'b0;
    chk("rst_after_start_busy", int'(m_busy), 1);
    wait_done("rst_after_done", 30);

    // parameter sweep: LAT0/6 rows, LAT3/6 rows, LAT1/1 row, from a clean reset
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    step();
    begin
      int         lat[3];
      int         rows[3];
      logic [3:0] hist[3];
      logic       sv[3], sr[3], sl[3], sd[3];
      int         si[3];
      int         nv[3], done_n[3], done_c[3], last_c[3];
      lat = '{0, 3, 1};
      rows = '{6, 6, 1};
      for (int d = 0; d < 3; d++) begin
        hist[d] = '0; nv[d] = 0; done_n[d] = 0; done_c[d] = -1; last_c[d] = -1;
      end
      done_comb = 1'b1;
      start = 1'b1;
      push_run();
      step();
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
        sv = '{z_row_valid, t_row_valid, o_row_valid};
        sr = '{z_rd_en, t_rd_en, o_rd_en};
        sl = '{z_last_row, t_last_row, o_last_row};
        sd = '{z_done, t_done, o_done};
        si = '{int'(z_row_idx), int'(t_row_idx), int'(o_row_idx)};
        for (int d = 0; d < 3; d++) begin
          hist[d] = {hist[d][2:0], sr[d]};
          chk($sformatf("sweep%0d_lat", d), int'(sv[d]), int'(hist[d][lat[d]]));
          if (sv[d]) begin
            chk($sformatf("sweep%0d_idx", d), si[d], nv[d]);
            chk($sformatf("sweep%0d_last", d), int'(sl[d]), (nv[d] == rows[d] - 1) ? 1 : 0);
            if (sl[d]) last_c[d] = c;
            nv[d]++;
          end
          if (sd[d]) begin
            done_n[d]++;
            done_c[d] = c;
          end
        end
        step();
      end
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("sweep%0d_rows", d), nv[d], rows[d]);
        chk($sformatf("sweep%0d_done_n", d), done_n[d], 1);
        chk($sformatf("sweep%0d_last_cyc", d), last_c[d], rows[d] + lat[d]);
        chk($sformatf("sweep%0d_done_cyc", d), done_c[d], rows[d] + lat[d] + 1);
      end
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
